// File: rtl/vid_pkg.sv
// Shared definitions for the horizontal video timing block: widths, register
// select codes and the blank/sync state encodings.
package vid_pkg;

  localparam int unsigned CW   = 11;
  localparam int unsigned NREG = 5;

  typedef enum logic [2:0] {
    SEL_HP  = 3'd0,
    SEL_HBB = 3'd1,
    SEL_HBE = 3'd2,
    SEL_HSS = 3'd3,
    SEL_HSE = 3'd4
  } reg_sel_e;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } blank_state_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SYNC = 1'b1
  } sync_state_e;

endpackage

// File: rtl/vid_htiming_ctrl_if.sv
// CPU-side register bus of the horizontal timing block: write strobe/select/data
// and the combinational readback port.
interface vid_htiming_ctrl_if;
  import vid_pkg::*;

  logic          wr_en;
  logic [2:0]    wr_sel;
  logic [CW-1:0] wr_data;
  logic [2:0]    rd_sel;
  logic [CW-1:0] rd_data;

  modport master (output wr_en, wr_sel, wr_data, rd_sel, input rd_data);
  modport slave  (input wr_en, wr_sel, wr_data, rd_sel, output rd_data);

endinterface

// File: rtl/hcmp_reg.sv
// One programmable compare register: loads on its write enable and flags
// equality against the running pixel counter.
module hcmp_reg
  import vid_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [CW-1:0] wr_data,
  input  logic [CW-1:0] hcount,
  output logic [CW-1:0] value,
  output logic          match
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (we) begin
      value <= wr_data;
    end
  end

  // Compares against the stored value, so a same-cycle write only takes effect next cycle.
  assign match = (value == hcount);

endmodule

// File: rtl/vid_htiming_ctrl.sv
// Horizontal timing sequencer: free-running pixel counter, five compare
// registers, and registered hblank/hsync/line_end generation.
module vid_htiming_ctrl
  import vid_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 ven,
  vid_htiming_ctrl_if.slave    reg_bus,
  output logic [CW-1:0]        hcount,
  output logic                 hblank,
  output logic                 hsync,
  output logic                 line_end
);

  logic [CW-1:0]   reg_val [NREG];
  logic [NREG-1:0] reg_we;
  logic [NREG-1:0] reg_match;

  blank_state_e blank_st;
  sync_state_e  sync_st;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign reg_we[i] = reg_bus.wr_en && (reg_bus.wr_sel == 3'(i));

    hcmp_reg u_hcmp_reg (
      .clk     (sys_clk),
      .rst     (reset),
      .we      (reg_we[i]),
      .wr_data (reg_bus.wr_data),
      .hcount  (hcount),
      .value   (reg_val[i]),
      .match   (reg_match[i])
    );
  end

  always_comb begin
    reg_bus.rd_data = '0;
    case (reg_bus.rd_sel)
      SEL_HP:  reg_bus.rd_data = reg_val[0];
      SEL_HBB: reg_bus.rd_data = reg_val[1];
      SEL_HBE: reg_bus.rd_data = reg_val[2];
      SEL_HSS: reg_bus.rd_data = reg_val[3];
      SEL_HSE: reg_bus.rd_data = reg_val[4];
      default: reg_bus.rd_data = '0;
    endcase
  end

  // Only an HP match restarts the line; the natural 2047->0 rollover is not a line end.
  always_ff @(posedge sys_clk) begin
    if (reset || !ven) begin
      hcount   <= '0;
      line_end <= 1'b0;
      blank_st <= ST_BLANK;
      hblank   <= 1'b1;
      sync_st  <= ST_IDLE;
      hsync    <= 1'b0;
    end else begin
      line_end <= reg_match[SEL_HP];
      hcount   <= reg_match[SEL_HP] ? '0 : hcount + 1'b1;

      case (blank_st)
        ST_BLANK:  if (reg_match[SEL_HBE]) begin
                     blank_st <= ST_ACTIVE;
                     hblank   <= 1'b0;
                   end
        ST_ACTIVE: if (reg_match[SEL_HBB]) begin
                     blank_st <= ST_BLANK;
                     hblank   <= 1'b1;
                   end
        default:   begin
                     blank_st <= ST_BLANK;
                     hblank   <= 1'b1;
                   end
      endcase

      case (sync_st)
        ST_IDLE: if (reg_match[SEL_HSS]) begin
                   sync_st <= ST_SYNC;
                   hsync   <= 1'b1;
                 end
        ST_SYNC: if (reg_match[SEL_HSE]) begin
                   sync_st <= ST_IDLE;
                   hsync   <= 1'b0;
                 end
        default: begin
                   sync_st <= ST_IDLE;
                   hsync   <= 1'b0;
                 end
      endcase
    end
  end

endmodule
